rr_output_arbiter: RTL and testbench
====================================

// Module: rr_output_arbiter
// PURPOSE
//  Parametrised round-robin arbiter for one router output port, the successor to the fixed
//  per-direction rr processors. Filters input requests by next-hop address match, grants one
//  input, and holds that grant for the whole packet (head to tail). After the tail flit it
//  rotates priority to the next input. One instance sits in front of each crossbar output.
// PARAMETERS
//  NUM_PORTS  5  number of router inputs competing (N,S,W,E,L = 0..4)
//  ADDR_W     3  width of each next-hop address field
//  PORT_ID    4  next-hop code owned by this output; a request matches when addr == PORT_ID
//  SELF_IDX   4  input index never granted (U-turn exclusion); SELF_IDX >= NUM_PORTS disables it
//  IDX_W      $clog2(NUM_PORTS)  width of grant index (derived, not overridden)
// PORTS
//  clk              in   1                  clock, rising edge
//  reset            in   1                  asynchronous reset, active-low
//  req_valid_i      in   NUM_PORTS          per-input flit valid
//  req_nexthop_i    in   NUM_PORTS*ADDR_W   per-input next-hop addr; input k at [k*ADDR_W +: ADDR_W]
//  req_tail_i       in   NUM_PORTS          per-input flit is the packet tail
//  out_ready_i      in   1                  downstream accepts a flit this cycle
//  grant_o          out  NUM_PORTS          one-hot grant (crossbar select)
//  grant_idx_o      out  IDX_W              binary index of granted input; 0 when none
//  grant_valid_o    out  1                  a grant is held (== |grant_o)
//  xfer_o           out  1                  flit handshake this cycle: grant_valid & req_valid[g] & out_ready
//  ptr_o            out  IDX_W              current round-robin pointer (debug/verification)
// BEHAVIOUR
//  - Eligible: elig[k] = req_valid_i[k] & (req_nexthop_i[k] == PORT_ID) & (k != SELF_IDX).
//  - Reset (reset==0, async): state=IDLE, ptr=0, grant_o=0, grant_idx_o=0, grant_valid_o=0;
//    xfer_o=0 since grant_valid_o=0. Takes effect immediately, also mid-packet; in-flight packet
//    is abandoned.
//  - FSM, two states:
//    IDLE: if |elig, pick the first eligible index searching ptr, ptr+1, ... NUM_PORTS-1, 0, ...
//      (wrap modulo NUM_PORTS). Register grant -> LOCKED. Else stay IDLE.
//    LOCKED: grant_o/grant_idx_o constant. On xfer_o & req_tail_i[g]: clear grant,
//      ptr <= (g == NUM_PORTS-1) ? 0 : g+1, -> IDLE. Otherwise stay LOCKED.
//  - Latency: elig seen in IDLE at edge t -> grant_o valid after edge t (1 cycle, registered).
//    Tail handshake at cycle t -> grant_o=0 at t+1. Earliest next grant is at t+2
//    (one bubble cycle per packet, by design).
//  - In LOCKED, other inputs' eligibility, and the granted input's address, are ignored.
//    Granted input dropping req_valid_i keeps the lock (no timeout, no abort).
//  - out_ready_i low: no xfer, lock held indefinitely.
//  - Single-flit packet (head==tail): handled as a tail on its first handshake.
//  - Pointer moves only on tail handshake, never on grant. Pointer may equal SELF_IDX; the
//    search simply skips it.
//  - Arbitration (IDLE) depends only on registered ptr and current inputs; no combinational
//    path from out_ready_i to grant_o.
// TESTING
//  1 reset low with random inputs -> grant_o=0, grant_valid_o=0, ptr_o=0, xfer_o=0
//  2 ptr=0, inputs 0 and 2 valid, addr=4, single-flit tails, out_ready=1 -> grant 5'b00001
//    at t+1, idle t+2, 5'b00100 at t+3, ptr_o=3 afterwards
//  3 input 1 granted, 3-flit packet, out_ready pattern 1,0,1,1; input 3 also requesting
//    -> grant_o stays 5'b00010 until the 3rd handshake; then grant 5'b01000 two cycles later
//  4 Wrap: input 3 finishes (ptr->4 = SELF_IDX); inputs 0,3,4 request -> input 0 granted,
//    input 4 never granted
//  5 Valid inputs with addr=2 (!=PORT_ID) on all ports -> grant_valid_o stays 0 for 20 cycles
//  6 reset pulsed low mid-packet while LOCKED on input 2 -> grant_o=0 immediately (before the
//    next edge), ptr_o=0, then IDLE re-arbitration after release

Source files
------------

// File: rtl/rr_output_arbiter.sv
// Round-robin output-port arbiter.
// Inputs whose next-hop address matches PORT_ID compete for one router output.
// The chosen input keeps the grant until its tail flit is accepted downstream.
// After that tail, priority rotates to the input that follows the one just served.
module rr_output_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_W    = 3,
    parameter int PORT_ID   = 4,
    parameter int SELF_IDX  = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_nexthop_i,
    input  logic [NUM_PORTS-1:0]        req_tail_i,
    input  logic                        out_ready_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic [IDX_W-1:0]            grant_idx_o,
    output logic                        grant_valid_o,
    output logic                        xfer_o,
    output logic [IDX_W-1:0]            ptr_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] gidx_reg, gidx_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    logic [NUM_PORTS-1:0] elig;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;

    // A request is eligible when it is valid, heads for this output, and is not a U-turn.
    // A SELF_IDX outside 0..NUM_PORTS-1 matches no input, so no input is excluded.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
            localparam bit IS_SELF = (gi == SELF_IDX);
            assign elig[gi] = req_valid_i[gi]
                            && (req_nexthop_i[gi*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
                            && !IS_SELF;
        end
    endgenerate

    // Find the first eligible input, starting at ptr and wrapping around modulo NUM_PORTS.
    // Only the registered ptr and the current inputs feed this search.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = int'(ptr_reg) + off;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && elig[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State register. Reset is asynchronous and abandons any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            gidx_reg  <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state: grant from IDLE; leave LOCKED only when the tail flit is accepted.
    // The pointer moves only on that tail handshake, never when a grant is issued.
    always_comb begin
        state_next = state_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = LOCKED;
                    gidx_next  = pick_idx;
                end
            end
            LOCKED: begin
                if (xfer_o && req_tail_i[gidx_reg]) begin
                    state_next = IDLE;
                    gidx_next  = '0;
                    ptr_next   = (gidx_reg == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                     : gidx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gidx_next  = '0;
            end
        endcase
    end

    // Outputs: decode the held grant and form the flit handshake.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        xfer_o        = 1'b0;
        if (state_reg == LOCKED) begin
            grant_o[gidx_reg] = 1'b1;
            grant_idx_o       = gidx_reg;
            grant_valid_o     = 1'b1;
            xfer_o            = req_valid_i[gidx_reg] & out_ready_i;
        end
    end

    assign ptr_o = ptr_reg;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed testbench for rr_output_arbiter with the default parameters:
// 5 inputs, PORT_ID = 4, and input 4 as the U-turn input.
module tb_rr_output_arbiter;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [14:0] req_nexthop;
    logic [4:0]  req_tail;
    logic        out_ready;
    logic [4:0]  grant;
    logic [2:0]  grant_idx;
    logic        grant_valid;
    logic        xfer;
    logic [2:0]  ptr;

    int n_checks = 0;
    int n_errors = 0;

    rr_output_arbiter dut (
        .clk           (clk),
        .reset         (rst_n),
        .req_valid_i   (req_valid),
        .req_nexthop_i (req_nexthop),
        .req_tail_i    (req_tail),
        .out_ready_i   (out_ready),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .xfer_o        (xfer),
        .ptr_o         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr_all(input logic [2:0] a);
        for (int k = 0; k < 5; k++) begin
            req_nexthop[k*3 +: 3] = a;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // 1: reset held low while the inputs change randomly
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        req_valid   = 5'($urandom);
        req_nexthop = 15'($urandom);
        req_tail    = 5'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            req_valid   = 5'($urandom);
            req_nexthop = 15'($urandom);
            req_tail    = 5'($urandom);
            #1;
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_gvalid", 32'(grant_valid), 32'h0);
            check("rst_idx", 32'(grant_idx), 32'h0);
            check("rst_ptr", 32'(ptr), 32'h0);
            check("rst_xfer", 32'(xfer), 32'h0);
        end
        req_valid = 5'b0;
        req_tail  = 5'b0;
        set_addr_all(3'd4);
        rst_n = 1'b1;
        tick();

        // 2: inputs 0 and 2 send single-flit packets, starting from ptr = 0
        req_valid = 5'b00101;
        req_tail  = 5'b11111;
        #1;
        check("t2_pre", 32'(grant), 32'h0);
        tick();
        check("t2_g0", 32'(grant), 32'b00001);
        check("t2_idx0", 32'(grant_idx), 32'h0);
        check("t2_xfer0", 32'(xfer), 32'h1);
        tick();
        check("t2_bubble", 32'(grant), 32'h0);
        check("t2_ptr1", 32'(ptr), 32'h1);
        req_valid = 5'b00100;
        tick();
        check("t2_g2", 32'(grant), 32'b00100);
        check("t2_idx2", 32'(grant_idx), 32'h2);
        tick();
        check("t2_idle", 32'(grant), 32'h0);
        check("t2_ptr3", 32'(ptr), 32'h3);

        // Input 0 sends one single-flit packet so that ptr ends at 1
        req_valid = 5'b00001;
        req_tail  = 5'b00001;
        tick();
        check("br_g0", 32'(grant), 32'b00001);
        tick();
        check("br_ptr1", 32'(ptr), 32'h1);
        req_valid = 5'b0;
        req_tail  = 5'b0;

        // 3: input 1 sends a 3-flit packet while input 3 also requests
        req_valid = 5'b01010;
        out_ready = 1'b1;
        tick();
        check("t3_g1", 32'(grant), 32'b00010);
        check("t3_xf1", 32'(xfer), 32'h1);
        tick();
        out_ready = 1'b0;
        #1;
        check("t3_hold_nr", 32'(grant), 32'b00010);
        check("t3_noxfer", 32'(xfer), 32'h0);
        tick();
        out_ready = 1'b1;
        #1;
        check("t3_hold2", 32'(grant), 32'b00010);
        check("t3_xf2", 32'(xfer), 32'h1);
        tick();
        req_tail = 5'b00010;
        #1;
        check("t3_hold3", 32'(grant), 32'b00010);
        check("t3_xf3", 32'(xfer), 32'h1);
        tick();
        req_tail  = 5'b0;
        req_valid = 5'b01000;
        #1;
        check("t3_bubble", 32'(grant), 32'h0);
        check("t3_ptr2", 32'(ptr), 32'h2);
        tick();
        check("t3_g3", 32'(grant), 32'b01000);
        check("t3_idx3", 32'(grant_idx), 32'h3);

        // 4: input 3 finishes, ptr wraps onto the U-turn input, and input 4 is never granted
        req_tail = 5'b01000;
        #1;
        check("t4_xf3", 32'(xfer), 32'h1);
        tick();
        req_valid = 5'b11001;
        req_tail  = 5'b0;
        #1;
        check("t4_ptr4", 32'(ptr), 32'h4);
        check("t4_idle", 32'(grant), 32'h0);
        tick();
        check("t4_g0", 32'(grant), 32'b00001);
        req_tail = 5'b00001;
        tick();
        check("t4_ptr1", 32'(ptr), 32'h1);
        req_valid = 5'b11000;
        req_tail  = 5'b0;
        tick();
        check("t4_g3", 32'(grant), 32'b01000);
        req_tail = 5'b01000;
        tick();
        req_valid = 5'b10000;
        req_tail  = 5'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_no_self", 32'(grant_valid), 32'h0);
        end
        check("t4_ptr_end", 32'(ptr), 32'h4);

        // 5: every input is valid but targets address 2, which is not this output
        req_valid = 5'b11111;
        set_addr_all(3'd2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_nomatch", 32'(grant_valid), 32'h0);
        end
        req_valid = 5'b0;
        set_addr_all(3'd4);
        tick();

        // 6: asynchronous reset in the middle of a packet from input 2
        req_valid = 5'b00100;
        req_tail  = 5'b0;
        out_ready = 1'b1;
        tick();
        check("t6_g2", 32'(grant), 32'b00100);
        tick();
        check("t6_locked", 32'(grant), 32'b00100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_gv", 32'(grant_valid), 32'h0);
        check("t6_rst_ptr", 32'(ptr), 32'h0);
        check("t6_rst_xfer", 32'(xfer), 32'h0);
        #1;
        rst_n     = 1'b1;
        req_valid = 5'b01100;
        tick();
        check("t6_rearb", 32'(grant), 32'b00100);
        check("t6_rearb_idx", 32'(grant_idx), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
